// File: rtl/segment_scan_if.sv
// rtl/segment_scan_if.sv - host-side load bus and display pin bundle for segment_scan_controller
interface segment_scan_if #(
    parameter int DIGITS = 8
);
    logic [31:0]       value;
    logic              load;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              frame_start;
    logic              pending;

    modport master (
        output value,
        output load,
        input  seg,
        input  an,
        input  frame_start,
        input  pending
    );

    modport slave (
        input  value,
        input  load,
        output seg,
        output an,
        output frame_start,
        output pending
    );
endinterface

// File: rtl/segment_scan_controller.sv
// rtl/segment_scan_controller.sv - multiplexed common-anode 7-segment scanner, frame-aligned value swap
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module segment_scan_controller #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    segment_scan_if.slave bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     r_pcnt;
    logic [IW-1:0]     r_idx;
    logic [31:0]       r_pend_reg;
    logic              r_pending;
    logic [31:0]       r_shadow;
    logic              r_frame_start;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_wrap;
    logic              w_boundary;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [6:0]        w_glyph;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_wrap     = (r_pcnt == PW'(DIV - 1));
    assign w_boundary = w_wrap && (r_idx == IW'(DIGITS - 1));
    assign w_nib      = r_shadow[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // Only nibbles that map to a physical digit count towards "leading".
    localparam logic [31:0] VIS_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << (4 * DIGITS)) - 32'd1);
    logic [31:0] w_upper;
    assign w_upper = (r_shadow & VIS_MASK) >> {r_idx, 2'b00};
    assign w_blank = (r_idx != '0) && (w_upper == 32'd0);
`else
    assign w_blank = 1'b0;
`endif

    assign w_glyph = w_blank ? 7'b1111111 : hex_decode(w_nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt        <= '0;
            r_idx         <= '0;
            r_pend_reg    <= '0;
            r_pending     <= 1'b0;
            r_shadow      <= '0;
            r_frame_start <= 1'b0;
            r_seg         <= 7'b1111111;
            r_an          <= '1;
        end else begin
            r_pcnt <= w_wrap ? '0 : r_pcnt + 1'b1;
            if (w_wrap) begin
                r_idx <= w_boundary ? '0 : r_idx + 1'b1;
            end
            r_frame_start <= w_boundary;

            // Swap reads the pre-edge pend_reg, so a load on the boundary waits one more frame.
            if (w_boundary && r_pending) begin
                r_shadow <= r_pend_reg;
            end
            if (bus.load) begin
                r_pend_reg <= bus.value;
                r_pending  <= 1'b1;
            end else if (w_boundary) begin
                r_pending  <= 1'b0;
            end

            r_an  <= ~(DIGITS'(1) << r_idx);
            r_seg <= w_glyph;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;
    assign bus.pending     = r_pending;
endmodule

// File: tb/tb_segment_scan_controller.sv
// tb/tb_segment_scan_controller.sv - scoreboard bench for segment_scan_controller with frame-level model
module tb_segment_scan_controller;
    localparam int D   = 4;
    localparam int V   = 4;
    localparam int FRM = D * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    segment_scan_if #(.DIGITS(D)) bus ();

    segment_scan_controller #(.DIGITS(D), .DIV(V)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned  edge_no;
        logic [6:0]   seg;
        logic [D-1:0] an;
        logic         fs;
        logic         pend;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;

    logic [6:0]  glyph[16];

    int unsigned m_n;
    logic [31:0] m_shadow;
    logic [31:0] m_pend;
    logic        m_pending;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [6:0] expect_seg(input logic [31:0] sh, input int i);
        logic [63:0] vis;
        logic [3:0]  nib;
        vis = {32'd0, sh} & ((64'd1 << (4 * D)) - 64'd1);
        nib = 4'((sh >> (4 * i)) & 32'hF);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (vis >> (4 * i)) == 64'd0) return 7'b1111111;
`else
        if (vis == 64'hFFFF_FFFF_FFFF_FFFF) return 7'b1111111;
`endif
        return glyph[nib];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
            mon_e = q.pop_front();
            checks++;
            if (bus.seg !== mon_e.seg || bus.an !== mon_e.an ||
                bus.frame_start !== mon_e.fs || bus.pending !== mon_e.pend) begin
                failures++;
                $display("FAIL scan edge %0d: got seg=%b an=%b fs=%b pend=%b expected seg=%b an=%b fs=%b pend=%b",
                         mon_e.edge_no, bus.seg, bus.an, bus.frame_start, bus.pending,
                         mon_e.seg, mon_e.an, mon_e.fs, mon_e.pend);
            end
        end
    end

    task automatic model_reset();
        m_n       = 0;
        m_shadow  = 32'd0;
        m_pend    = 32'd0;
        m_pending = 1'b0;
    endtask

    // Called just after a rising edge; predicts what the next edge produces.
    task automatic step(input logic ld, input logic [31:0] v);
        exp_t e;
        int   idx;
        logic bnd;
        bus.load  = ld;
        bus.value = v;
        idx = int'((m_n / V) % D);
        bnd = ((m_n % FRM) == FRM - 1);
        e.edge_no = edge_cnt + 1;
        for (int k = 0; k < D; k++) e.an[k] = (k != idx);
        e.seg  = expect_seg(m_shadow, idx);
        e.fs   = bnd;
        e.pend = ld ? 1'b1 : (bnd ? 1'b0 : m_pending);
        q.push_back(e);
        if (bnd && m_pending) m_shadow = m_pend;
        if (ld) m_pend = v;
        m_pending = e.pend;
        m_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark(input string tag);
        chk({tag, " seg"}, {25'd0, bus.seg}, 32'h7F);
        chk({tag, " an"}, {28'd0, bus.an}, 32'hF);
        chk({tag, " pending"}, {31'd0, bus.pending}, 32'd0);
        chk({tag, " frame_start"}, {31'd0, bus.frame_start}, 32'd0);
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

        bus.load  = 1'b0;
        bus.value = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_dark("reset");
        rst_n = 1'b1;
        model_reset();

        // Directed: idle frames, mid-frame load, double load, boundary load, leading zeros.
        for (int c = 0; c < 140; c++) begin
            case (c)
                37:      step(1'b1, 32'h0000_A7C3);
                50:      step(1'b1, 32'h0000_1111);
                55:      step(1'b1, 32'h0000_2222);
                70:      step(1'b1, 32'h0000_1111);
                79:      step(1'b1, 32'h0000_5555);
                100:     step(1'b1, 32'h0000_0050);
                default: step(1'b0, $urandom);
            endcase
        end

        for (int c = 0; c < 600; c++) begin
            logic [31:0] v;
            v = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            step($urandom_range(0, 7) == 0, v);
        end

        // Mid-frame asynchronous reset while a value is pending.
        step(1'b1, 32'h0000_BEEF);
        repeat (5) step(1'b0, 32'd0);
        rst_n = 1'b0;
        q.delete();
        #1;
        check_dark("async reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 40; c++) step(1'b0, $urandom);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
